// File: rtl/display_pkg.sv
// display_pkg
// Shared display types and constants for the layer compositor.
//   rgb_t        : 24-bit RGB888 pixel, red in [23:16], blue in [7:0]
//   layer_box_t  : inclusive rectangle bounds of one sprite layer
//   FIELD_*      : default game-field border position
//   BORDER_*     : border colours (idle white, flashing red)
//   blend_half() : 50% blend of two pixels, per 8-bit channel
package display_pkg;

  localparam int FIELD_W_DEFAULT = 960;
  localparam int FIELD_H_DEFAULT = 640;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BORDER_WHITE = 24'hFF_FF_FF;
  localparam rgb_t BORDER_RED   = 24'hFF_00_00;
  localparam rgb_t COLOR_BLACK  = 24'h00_00_00;

  typedef struct packed {
    logic [11:0] x;
    logic [10:0] y;
    logic [11:0] xmax;
    logic [10:0] ymax;
  } layer_box_t;

  // Each channel is (top >> 1) + (under >> 1). Both halves are at most
  // 127, so the sum is at most 254 and the 8-bit result cannot overflow.
  function automatic rgb_t blend_half(rgb_t top, rgb_t under);
    rgb_t res;
    res = COLOR_BLACK;
    for (int c = 0; c < 3; c++) begin
      res[c*8 +: 8] = {1'b0, top[c*8+1 +: 7]} + {1'b0, under[c*8+1 +: 7]};
    end
    return res;
  endfunction

endpackage

// File: rtl/layer_hit_test.sv
// layer_hit_test
// Purely combinational bounds test of one pixel against one layer box.
//   i_hcount, i_vcount : pixel coordinates
//   i_box              : inclusive bounds (x..xmax, y..ymax)
//   i_en               : layer enable
//   o_hit              : pixel lies inside an enabled box
// All compares are unsigned at 12 bits. A box with x > xmax or y > ymax
// has an empty range and therefore never hits.
module layer_hit_test
  import display_pkg::*;
(
  input  logic [10:0] i_hcount,
  input  logic [9:0]  i_vcount,
  input  layer_box_t  i_box,
  input  logic        i_en,
  output logic        o_hit
);

  logic [11:0] w_h;
  logic [11:0] w_v;
  logic [11:0] w_y;
  logic [11:0] w_ymax;

  assign w_h    = {1'b0, i_hcount};
  assign w_v    = {2'b00, i_vcount};
  assign w_y    = {1'b0, i_box.y};
  assign w_ymax = {1'b0, i_box.ymax};

  assign o_hit = i_en
               & (w_h >= i_box.x) & (w_h <= i_box.xmax)
               & (w_v >= w_y)     & (w_v <= w_ymax);

endmodule

// File: rtl/game_layer_compositor.sv
// game_layer_compositor
// Composites NUM_LAYERS rectangular sprite layers over a black background
// and draws a game-field border line that can flash red after a hit.
//   clk_in, rst_in          : pixel clock, synchronous active-high reset
//   hcount_in, vcount_in    : current pixel coordinates
//   nf_in                   : new-frame strobe; latches layer setup, ticks flash
//   box_*_in                : per-layer inclusive bounds
//   layer_color_in          : per-layer RGB888 colour
//   layer_en_in/_trans_in   : per-layer enable and 50% transparency
//   hit_in                  : (re)starts the border flash
//   pixel_out               : composited pixel, 2 cycles after its coordinates
//   hcount_out, vcount_out  : coordinates aligned with pixel_out
// Stage 1 registers per-layer hits and the border flag; stage 2 blends the
// hits in priority order (layer 0 on top) and registers the result.
module game_layer_compositor
  import display_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int FIELD_W      = FIELD_W_DEFAULT,
  parameter int FIELD_H      = FIELD_H_DEFAULT,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         nf_in,
  input  logic [NUM_LAYERS-1:0][11:0]  box_x_in,
  input  logic [NUM_LAYERS-1:0][11:0]  box_xmax_in,
  input  logic [NUM_LAYERS-1:0][10:0]  box_y_in,
  input  logic [NUM_LAYERS-1:0][10:0]  box_ymax_in,
  input  logic [NUM_LAYERS-1:0][23:0]  layer_color_in,
  input  logic [NUM_LAYERS-1:0]        layer_en_in,
  input  logic [NUM_LAYERS-1:0]        layer_trans_in,
  input  logic                         hit_in,
  output logic [23:0]                  pixel_out,
  output logic [10:0]                  hcount_out,
  output logic [9:0]                   vcount_out
);

  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  // Shadow copies of the layer setup, only updated on nf_in so geometry
  // and colours stay stable for a whole frame.
  layer_box_t            r_box   [NUM_LAYERS];
  rgb_t                  r_color [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_en;
  logic [NUM_LAYERS-1:0] r_trans;

  logic [NUM_LAYERS-1:0] w_hit;
  logic [NUM_LAYERS-1:0] r_s1_hit;
  logic [10:0]           r_s1_h;
  logic [9:0]            r_s1_v;
  logic                  r_s1_border;

  logic [FLASH_W-1:0]    r_flash_cnt;
  logic                  w_flash_bit2;
  logic                  w_border;
  rgb_t                  w_border_color;
  rgb_t                  w_comp;
  rgb_t                  w_pixel;

  // Per-layer shadow registers and bounds test
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_box[gi]   <= '0;
        r_color[gi] <= '0;
        r_en[gi]    <= 1'b0;
        r_trans[gi] <= 1'b0;
      end else if (nf_in) begin
        r_box[gi]   <= '{x: box_x_in[gi], y: box_y_in[gi],
                         xmax: box_xmax_in[gi], ymax: box_ymax_in[gi]};
        r_color[gi] <= layer_color_in[gi];
        r_en[gi]    <= layer_en_in[gi];
        r_trans[gi] <= layer_trans_in[gi];
      end
    end

    layer_hit_test u_hit (
      .i_hcount (hcount_in),
      .i_vcount (vcount_in),
      .i_box    (r_box[gi]),
      .i_en     (r_en[gi]),
      .o_hit    (w_hit[gi])
    );
  end

  // Border line: vertical at x=FIELD_W and horizontal at y=FIELD_H,
  // each clipped to the field extent. Compared at 12 bits.
  assign w_border = (({1'b0, hcount_in} == 12'(FIELD_W)) &&
                     ({2'b00, vcount_in} <= 12'(FIELD_H))) ||
                    (({2'b00, vcount_in} == 12'(FIELD_H)) &&
                     ({1'b0, hcount_in} <= 12'(FIELD_W)));

  // Stage 1
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_hit    <= '0;
      r_s1_h      <= '0;
      r_s1_v      <= '0;
      r_s1_border <= 1'b0;
    end else begin
      r_s1_hit    <= w_hit;
      r_s1_h      <= hcount_in;
      r_s1_v      <= vcount_in;
      r_s1_border <= w_border;
    end
  end

  // Flash counter: a hit reloads even when a frame tick arrives together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_flash_cnt <= '0;
    end else if (hit_in) begin
      r_flash_cnt <= FLASH_W'(FLASH_FRAMES);
    end else if (nf_in && (r_flash_cnt != '0)) begin
      r_flash_cnt <= r_flash_cnt - FLASH_W'(1);
    end
  end

  // A counter narrower than 3 bits has no bit 2, so it never shows red.
  if (FLASH_W > 2) begin : g_bit2
    assign w_flash_bit2 = r_flash_cnt[2];
  end else begin : g_no_bit2
    assign w_flash_bit2 = 1'b0;
  end

  assign w_border_color = ((r_flash_cnt != '0) && w_flash_bit2) ? BORDER_RED
                                                                 : BORDER_WHITE;

  // Stage 2 compositing: walk from the lowest-priority layer up to layer 0
  always_comb begin
    w_comp = COLOR_BLACK;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_comp = r_trans[i] ? blend_half(r_color[i], w_comp) : r_color[i];
      end
    end
    w_pixel = r_s1_border ? w_border_color : w_comp;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_out  <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      pixel_out  <= w_pixel;
      hcount_out <= r_s1_h;
      vcount_out <= r_s1_v;
    end
  end

endmodule

// File: tb/tb_game_layer_compositor.sv
// tb_game_layer_compositor
// Self-checking bench: every driven pixel pushes its expected output onto a
// queue; the entry is popped and compared two clock edges later.
module tb_game_layer_compositor;
  localparam int NL = 4;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic [10:0]          hcount_in = '0;
  logic [9:0]           vcount_in = '0;
  logic                 nf_in = 1'b0;
  logic [NL-1:0][11:0]  box_x_in = '0;
  logic [NL-1:0][11:0]  box_xmax_in = '0;
  logic [NL-1:0][10:0]  box_y_in = '0;
  logic [NL-1:0][10:0]  box_ymax_in = '0;
  logic [NL-1:0][23:0]  layer_color_in = '0;
  logic [NL-1:0]        layer_en_in = '0;
  logic [NL-1:0]        layer_trans_in = '0;
  logic                 hit_in = 1'b0;
  logic [23:0]          pixel_out;
  logic [10:0]          hcount_out;
  logic [9:0]           vcount_out;

  game_layer_compositor #(.NUM_LAYERS(NL)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .nf_in          (nf_in),
    .box_x_in       (box_x_in),
    .box_xmax_in    (box_xmax_in),
    .box_y_in       (box_y_in),
    .box_ymax_in    (box_ymax_in),
    .layer_color_in (layer_color_in),
    .layer_en_in    (layer_en_in),
    .layer_trans_in (layer_trans_in),
    .hit_in         (hit_in),
    .pixel_out      (pixel_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          chk;
    logic [23:0] pix;
    logic [10:0] h;
    logic [9:0]  v;
    string       name;
  } exp_t;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [23:0] pix;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fcnt  = 0;   // bench model of the flash counter

  task automatic compare(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // Drive one pixel for one clock; compare whatever entry is now due.
  task automatic cycle(input bit chk, input int h, input int v,
                       input logic [23:0] pix, input string name);
    exp_t e;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    exp_q.push_back('{chk, pix, 11'(h), 10'(v), name});
    @(posedge clk_in);
    #1;
    nf_in  = 1'b0;
    hit_in = 1'b0;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        compare({e.name, ".pix"}, pixel_out, e.pix);
        compare({e.name, ".h"}, {13'd0, hcount_out}, {13'd0, e.h});
        compare({e.name, ".v"}, {14'd0, vcount_out}, {14'd0, e.v});
        $display("pixel (%0d,%0d) %s -> %06h", e.h, e.v, e.name, pixel_out);
      end
    end
  endtask

  task automatic set_layer(input int i, input int x, input int y, input int xm,
                           input int ym, input logic [23:0] col, input bit en, input bit tr);
    box_x_in[i]       = 12'(x);
    box_y_in[i]       = 11'(y);
    box_xmax_in[i]    = 12'(xm);
    box_ymax_in[i]    = 11'(ym);
    layer_color_in[i] = col;
    layer_en_in[i]    = en;
    layer_trans_in[i] = tr;
  endtask

  task automatic load_frame();
    nf_in = 1'b1;
    if (fcnt > 0) fcnt--;
    cycle(0, 0, 0, 24'h0, "nf");
  endtask

  task automatic do_reset();
    cycle(0, 959, 300, 24'h0, "drain");
    cycle(0, 959, 300, 24'h0, "drain");
    exp_q.delete();
    rst_in = 1'b1;
    fcnt   = 0;
    @(posedge clk_in);
    #1;
    compare("rst.pix", pixel_out, 24'h0);
    compare("rst.h", {13'd0, hcount_out}, 24'h0);
    compare("rst.v", {14'd0, vcount_out}, 24'h0);
    $display("reset -> pix %06h h %0d v %0d", pixel_out, hcount_out, vcount_out);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  function automatic logic [23:0] border_exp();
    return ((fcnt != 0) && ((fcnt & 4) != 0)) ? 24'hFF0000 : 24'hFFFFFF;
  endfunction

  vec_t s1[11];
  vec_t s2[5];

  initial begin
    s1[0]  = '{11'd150, 10'd120, 24'h00FF00, "in_box"};
    s1[1]  = '{11'd200, 10'd120, 24'h000000, "right_of_box"};
    s1[2]  = '{11'd100, 10'd100, 24'h00FF00, "top_left"};
    s1[3]  = '{11'd199, 10'd149, 24'h00FF00, "bot_right"};
    s1[4]  = '{11'd99,  10'd120, 24'h000000, "left_of_box"};
    s1[5]  = '{11'd150, 10'd150, 24'h000000, "below_box"};
    s1[6]  = '{11'd960, 10'd300, 24'hFFFFFF, "vborder"};
    s1[7]  = '{11'd960, 10'd640, 24'hFFFFFF, "corner"};
    s1[8]  = '{11'd960, 10'd641, 24'h000000, "vborder_end"};
    s1[9]  = '{11'd961, 10'd640, 24'h000000, "hborder_end"};
    s1[10] = '{11'd0,   10'd640, 24'hFFFFFF, "hborder"};

    s2[0] = '{11'd150, 10'd120, 24'h7F007F, "trans_over_opaque"};
    s2[1] = '{11'd405, 10'd405, 24'h102030, "trans_over_black"};
    s2[2] = '{11'd409, 10'd409, 24'h102030, "trans_edge"};
    s2[3] = '{11'd410, 10'd409, 24'h000000, "trans_outside"};
    s2[4] = '{11'd505, 10'd505, 24'h000000, "disabled_layer"};

    // Power-on reset; layer 0 set up but not yet latched
    set_layer(0, 100, 100, 199, 149, 24'h00FF00, 1'b1, 1'b0);
    do_reset();
    cycle(1, 150, 120, 24'h000000, "before_first_nf");
    cycle(1, 150, 120, 24'h000000, "before_first_nf2");

    // Scene 1: single opaque layer plus border
    load_frame();
    foreach (s1[k]) cycle(1, int'(s1[k].h), int'(s1[k].v), s1[k].pix, s1[k].name);

    // Colour change without a frame strobe must not show
    layer_color_in[0] = 24'h0000FF;
    cycle(1, 150, 120, 24'h00FF00, "hold_old_color");
    load_frame();
    cycle(1, 150, 120, 24'h0000FF, "new_color");

    // Scene 2: transparency and enable
    set_layer(0, 100, 100, 199, 149, 24'hFF0000, 1'b1, 1'b1);
    set_layer(1, 100, 100, 199, 149, 24'h0000FE, 1'b1, 1'b0);
    set_layer(2, 400, 400, 409, 409, 24'h204060, 1'b1, 1'b1);
    set_layer(3, 500, 500, 510, 510, 24'h123456, 1'b0, 1'b0);
    load_frame();
    foreach (s2[k]) cycle(1, int'(s2[k].h), int'(s2[k].v), s2[k].pix, s2[k].name);

    // Scene 3: layer under the border; inverted box never drawn
    set_layer(0, 0, 0, 0, 0, 24'h0, 1'b0, 1'b0);
    set_layer(1, 300, 0, 299, 639, 24'hABCDEF, 1'b1, 1'b0);
    set_layer(2, 955, 295, 965, 305, 24'h00AA00, 1'b1, 1'b0);
    set_layer(3, 0, 0, 0, 0, 24'h0, 1'b0, 1'b0);
    load_frame();
    cycle(1, 299, 100, 24'h000000, "inverted_box_a");
    cycle(1, 300, 100, 24'h000000, "inverted_box_b");
    cycle(1, 959, 300, 24'h00AA00, "layer_near_border");
    cycle(1, 960, 300, border_exp(), "border_overrides");

    // Flash run-down after a hit
    hit_in = 1'b1;
    fcnt   = 30;
    cycle(0, 0, 0, 24'h0, "hit");
    for (int k = 1; k <= 31; k++) begin
      load_frame();
      cycle(1, 960, 300, border_exp(), $sformatf("flash_f%0d", k));
    end

    // Reload during an active flash, with a frame strobe in the same cycle
    hit_in = 1'b1;
    fcnt   = 30;
    cycle(0, 0, 0, 24'h0, "hit2");
    for (int k = 0; k < 5; k++) load_frame();
    cycle(1, 960, 300, border_exp(), "flash_at_25");
    hit_in = 1'b1;
    nf_in  = 1'b1;
    fcnt   = 30;
    cycle(0, 0, 0, 24'h0, "hit_and_nf");
    cycle(1, 960, 300, border_exp(), "reload_30");
    for (int k = 1; k <= 3; k++) begin
      load_frame();
      cycle(1, 960, 300, border_exp(), $sformatf("reload_f%0d", k));
    end

    // Reset mid-flash with layers active
    do_reset();
    cycle(1, 959, 300, 24'h000000, "post_rst_no_layer");
    cycle(1, 960, 300, 24'hFFFFFF, "post_rst_border");
    load_frame();
    cycle(1, 959, 300, 24'h00AA00, "post_rst_layer_back");
    cycle(0, 0, 0, 24'h0, "drain");
    cycle(0, 0, 0, 24'h0, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
